// File: rtl/add_sub_defs_pkg.sv
// ============================================================================
// Module      : add_sub_defs (package)
// Description : Mode and FSM state encodings shared by the serial add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_sub_defs;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/add_slice.sv
// ============================================================================
// Module      : add_slice
// Description : DIGIT-bit combinational ripple adder slice with the carry into
//               its top bit exposed for signed-overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_total;

    assign w_total  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign s        = w_total[DIGIT-1:0];
    assign co       = w_total[DIGIT];
    // A sum bit is x ^ y ^ carry-in, so the top bit's carry-in falls out directly.
    assign c_msb_in = w_total[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// Module      : serial_add_sub
// Description : Multi-cycle add/subtract unit, DIGIT bits per clock through a
//               registered carry chain. Define SERIAL_ADD_SAT_EN to saturate
//               the sum on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub
    import add_sub_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q,  carry_d;
    logic               mode_q,   mode_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   done_q;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic [DIGIT-1:0]   w_s;
    logic               w_co;
    logic               w_cmsb;
    logic [WIDTH-1:0]   w_res_next;

    add_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x        (a_sh_q[DIGIT-1:0]),
        .y        (b_sh_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_cmsb)
    );

    // New slice enters at the top; after STEPS shifts the word is in place.
    assign w_res_next = WIDTH'({w_s, res_sh_q} >> DIGIT);

`ifdef SERIAL_ADD_SAT_EN
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = (mode == MODE_SUB) ? ~b : b;
                    carry_d = (mode == MODE_SUB) ? ~cin : cin;
                    mode_d  = mode;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                res_sh_d = w_res_next;
                carry_d  = w_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    sum_d   = w_res_next;
                    cout_d  = (mode_q == MODE_ADD) ? w_co : ~w_co;
                    ovf_d   = w_cmsb ^ w_co;
`ifdef SERIAL_ADD_SAT_EN
                    // On overflow the wrapped sign is the opposite of the true sign.
                    if (w_cmsb ^ w_co) begin
                        sum_d = w_res_next[WIDTH-1] ? POS_MAX : NEG_MIN;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            mode_q   <= MODE_ADD;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire
